despachador_llamadas: RTL and testbench
=======================================

# despachador_llamadas

- Upstream stage of `controlador_ascensores`.
- Latches hall-call buttons for the four floors (codes 00 = −1, 01 = 1, 10 = 2, 11 = 3).
- Assigns each pending call to the nearest free elevator and drives a per-elevator destination with a valid flag.
- Clears a call when an elevator opens its doors at that floor; reclaims assignments that time out.

## Interface
- `TIMEOUT_CICLOS`, 500000000, cycles an assignment may stay unserved before it is reclaimed (10 s at 50 MHz).
- `DEBOUNCE_CICLOS`, 1000000, consecutive stable cycles required by the debounce filter (used only with `DEBOUNCE_EN`).
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset; one clock, synchronous and active-high.
- `boton_llamada`  in  4  raw hall buttons; bit i = floor code i; level, high = pressed.
- `piso_asc_1`, `piso_asc_2`  in  2 each  current floor code of each elevator.
- `puertas_abiertas_asc_1`, `puertas_abiertas_asc_2`  in  1 each  door-open level of each elevator.
- `llamada_pendiente`  out  4  call lamps; bit i = call latched at floor i.
- `destino_asc_1`, `destino_asc_2`  out  2 each  assigned floor code.
- `destino_valido_asc_1`, `destino_valido_asc_2`  out  1 each  assignment active.
- `atendido_asc_1`, `atendido_asc_2`  out  1 each  one-cycle pulse: own assignment served.
- `timeout_asc_1`, `timeout_asc_2`  out  1 each  one-cycle pulse: assignment reclaimed.

## Operation
- **Button edge:** `boton_q` registers `boton_llamada`. A rising edge (`boton & ~boton_q`) sets `llamada_pendiente[i]`. A held button does not re-trigger.
- **Service event:** a rising edge of `puertas_abiertas_asc_n` (vs. its registered copy) while `piso_asc_n == i` clears `llamada_pendiente[i]` and `asignado[i]`.
  - If elevator n holds `destino_valido` with `destino == i`: clear its valid flag and pulse `atendido_asc_n`.
  - If the *other* elevator held floor i: clear its valid flag silently, with no pulse.
- **Dispatch FSM:** `ptr[1:0]` is the round-robin scan pointer. An elevator is *free* when its `destino_valido` is 0.
  - **ESPERA:** go to BUSCA if any `llamada_pendiente & ~asignado` bit is set and at least one elevator is free.
  - **BUSCA:** if floor `ptr` is pending and unassigned, latch the chosen elevator and go to ASIGNA. Otherwise `ptr <= ptr+1` (3 wraps to 0) and stay. If no elevator is free, return to ESPERA.
  - **ASIGNA:** load `destino_asc_n <= ptr` and set `destino_valido_asc_n`, set `asignado[ptr]`, then `ptr <= ptr+1` and return to ESPERA.
- **Elevator selection:** distance = |piso − ptr|, computed as a 3-bit unsigned difference of zero-extended codes. Choose the free elevator with the smaller distance; a tie goes to elevator 1. Distance 0 is legal.
- **Timeout:** a 34-bit counter per elevator counts while its valid flag is high and clears when the flag is low. On reaching `TIMEOUT_CICLOS`:
  - clear the valid flag and `asignado[destino]`;
  - keep `llamada_pendiente`;
  - pulse `timeout_asc_n`;
  - reset the counter.

## Timing
- **Reset values:** every output, `asignado`, `boton_q`, door copies, counters and `ptr` are 0; FSM = ESPERA. A reset mid-assignment drops all calls.
- **Lamp latency:** `llamada_pendiente[i]` is high the cycle after the first sampled high level of the button.
- **Assignment latency:** pending to `destino_valido` takes 3 cycles minimum (ESPERA→BUSCA→ASIGNA→output) and 6 maximum (worst-case full scan).
- `atendido` and `timeout` are exactly one cycle wide. A valid flag falls in the same cycle as its pulse.
- **Simultaneous events on one floor, same cycle:**
  - Press and service: service wins, so the call is not latched.
  - Service and ASIGNA: service wins, so no assignment is made and ASIGNA falls back to ESPERA.
  - Timeout and service: service wins, so `atendido` pulses and `timeout` does not.
- Both elevators serving different floors in the same cycle are processed independently.
- Only one assignment is made per ASIGNA visit.

## Configuration
- `DESPACHADOR_DEBOUNCE_EN` defined: each button bit first passes a counter filter. The filtered level changes only after `DEBOUNCE_CICLOS` consecutive cycles at the new raw value. Edge detection uses the filtered level, so lamp latency = `DEBOUNCE_CICLOS` + 1.
- `DESPACHADOR_DEBOUNCE_EN` undefined: no filter; raw input goes straight to `boton_q`. `DEBOUNCE_CICLOS` is unused.

## Test plan
- Reset; raise `boton_llamada` = 0100 with elevator 1 at 01 and elevator 2 at 11 → `llamada_pendiente` = 0100 next cycle; `destino_asc_1` = 10 with valid ≤ 6 cycles later (tie-break to elevator 1).
- Elevator 1 at 10 with pending floor 10 assigned; pulse a door-open rising edge → `llamada_pendiente[2]` = 0, `destino_valido_asc_1` = 0, and `atendido_asc_1` high for exactly 1 cycle.
- Calls 0001 and 1000, elevators at 00 and 11 → `destino_asc_1` = 00 and `destino_asc_2` = 11, both valid.
- Run with `TIMEOUT_CICLOS` = 20 and no service → `timeout_asc_1` pulse at count 20; lamp stays 1; the call is reassigned within 6 cycles.
- Button press on floor 01 in the same cycle as elevator 2's door-open rising edge at 01 → lamp stays 0; no assignment.
- With `DESPACHADOR_DEBOUNCE_EN` defined and `DEBOUNCE_CICLOS` = 8, a 5-cycle glitch → no call latched; a 9-cycle press → call latched.

Source files
------------

// File: rtl/despachador_llamadas.sv
// Hall-call dispatcher: latches floor calls, hands each to the nearest free elevator,
// clears calls on service and reclaims stale assignments. Define DESPACHADOR_DEBOUNCE_EN to filter buttons.
//
// state  | meaning
// ESPERA | idle until an unassigned call and a free elevator both exist
// BUSCA  | round-robin scan at ptr for a pending, unassigned floor
// ASIGNA | load the chosen elevator with floor ptr
module despachador_llamadas #(
    parameter int unsigned TIMEOUT_CICLOS  = 500000000,
    parameter int unsigned DEBOUNCE_CICLOS = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] boton_llamada,
    input  logic [1:0] piso_asc_1,
    input  logic [1:0] piso_asc_2,
    input  logic       puertas_abiertas_asc_1,
    input  logic       puertas_abiertas_asc_2,
    output logic [3:0] llamada_pendiente,
    output logic [1:0] destino_asc_1,
    output logic [1:0] destino_asc_2,
    output logic       destino_valido_asc_1,
    output logic       destino_valido_asc_2,
    output logic       atendido_asc_1,
    output logic       atendido_asc_2,
    output logic       timeout_asc_1,
    output logic       timeout_asc_2
);
    typedef enum logic [1:0] {ESPERA, BUSCA, ASIGNA} estado_t;

    localparam logic [33:0] TO_FIN = 34'(TIMEOUT_CICLOS) - 34'd1;

    estado_t         estado;
    logic [1:0]      ptr;
    logic            elegido;
    logic            elige_2;
    logic            asigna_ok;
    logic [3:0]      boton;
    logic [3:0]      boton_q;
    logic [3:0]      asignado;
    logic [3:0]      asignado_sig;
    logic [3:0]      clr_srv;
    logic [3:0]      clr_to;
    logic [3:0]      set_asig;
    logic [1:0]      puertas;
    logic [1:0]      puertas_q;
    logic [1:0]      servicio;
    logic [1:0]      propio;
    logic [1:0]      libera;
    logic [1:0]      fin;
    logic [1:0]      valido;
    logic [1:0]      atendido;
    logic [1:0]      timeout_p;
    logic [1:0][1:0] piso;
    logic [1:0][1:0] destino;
    logic [1:0][33:0] cnt;

    function automatic logic [2:0] distancia(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] za;
        logic [2:0] zb;
        za = {1'b0, a};
        zb = {1'b0, b};
        return (za >= zb) ? za - zb : zb - za;
    endfunction

`ifdef DESPACHADOR_DEBOUNCE_EN
    logic [3:0]       boton_filt;
    logic [3:0][31:0] deb_cnt;

    // Filtered level flips only after DEBOUNCE_CICLOS consecutive samples at the new raw value.
    always_ff @(posedge clk) begin
        if (rst) begin
            boton_filt <= '0;
            deb_cnt    <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (boton_llamada[i] == boton_filt[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEBOUNCE_CICLOS - 1) begin
                    boton_filt[i] <= boton_llamada[i];
                    deb_cnt[i]    <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 32'd1;
                end
            end
        end
    end

    assign boton = boton_filt;
`else
    assign boton = boton_llamada;
`endif

    assign piso    = {piso_asc_2, piso_asc_1};
    assign puertas = {puertas_abiertas_asc_2, puertas_abiertas_asc_1};

    // Service always beats timeout and a same-cycle assignment on the same floor.
    always_comb begin
        servicio = puertas & ~puertas_q;
        clr_srv  = '0;
        clr_to   = '0;
        propio   = '0;
        libera   = '0;
        fin      = '0;
        for (int n = 0; n < 2; n++) begin
            if (servicio[n]) clr_srv = clr_srv | (4'b0001 << piso[n]);
            propio[n] = servicio[n] & valido[n] & (destino[n] == piso[n]);
            libera[n] = propio[n] | (servicio[1-n] & valido[n] & (destino[n] == piso[1-n]));
            fin[n]    = valido[n] & (cnt[n] == TO_FIN) & ~libera[n];
            if (fin[n]) clr_to = clr_to | (4'b0001 << destino[n]);
        end
        asigna_ok    = (estado == ASIGNA) & llamada_pendiente[ptr] & ~asignado[ptr] & ~clr_srv[ptr];
        set_asig     = asigna_ok ? (4'b0001 << ptr) : 4'b0000;
        asignado_sig = (asignado & ~clr_srv & ~clr_to) | set_asig;
        elige_2      = ~valido[1] & (valido[0] | (distancia(piso[1], ptr) < distancia(piso[0], ptr)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado            <= ESPERA;
            ptr               <= '0;
            elegido           <= 1'b0;
            boton_q           <= '0;
            puertas_q         <= '0;
            llamada_pendiente <= '0;
            asignado          <= '0;
            destino           <= '0;
            valido            <= '0;
            atendido          <= '0;
            timeout_p         <= '0;
            cnt               <= '0;
        end else begin
            boton_q           <= boton;
            puertas_q         <= puertas;
            llamada_pendiente <= (llamada_pendiente | (boton & ~boton_q)) & ~clr_srv;
            asignado          <= asignado_sig;
            atendido          <= propio;
            timeout_p         <= fin;
            for (int n = 0; n < 2; n++) begin
                if (libera[n] | fin[n]) valido[n] <= 1'b0;
                cnt[n] <= (valido[n] & ~libera[n] & ~fin[n]) ? cnt[n] + 34'd1 : 34'd0;
            end
            case (estado)
                ESPERA: begin
                    if ((|(llamada_pendiente & ~asignado)) && !(&valido)) estado <= BUSCA;
                end
                BUSCA: begin
                    if (&valido) begin
                        estado <= ESPERA;
                    end else if (llamada_pendiente[ptr] && !asignado[ptr]) begin
                        elegido <= elige_2;
                        estado  <= ASIGNA;
                    end else begin
                        ptr <= ptr + 2'd1;
                    end
                end
                ASIGNA: begin
                    estado <= ESPERA;
                    if (asigna_ok) begin
                        destino[elegido] <= ptr;
                        valido[elegido]  <= 1'b1;
                        ptr              <= ptr + 2'd1;
                    end
                end
                default: estado <= ESPERA;
            endcase
        end
    end

    assign destino_asc_1        = destino[0];
    assign destino_asc_2        = destino[1];
    assign destino_valido_asc_1 = valido[0];
    assign destino_valido_asc_2 = valido[1];
    assign atendido_asc_1       = atendido[0];
    assign atendido_asc_2       = atendido[1];
    assign timeout_asc_1        = timeout_p[0];
    assign timeout_asc_2        = timeout_p[1];
endmodule

// File: tb/tb_despachador_llamadas.sv
// Bench for despachador_llamadas: per-elevator scoreboards of expected destinations, scenario tasks.
module tb_despachador_llamadas;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] boton_llamada;
    logic [1:0] piso_asc_1, piso_asc_2;
    logic       puertas_abiertas_asc_1, puertas_abiertas_asc_2;
    logic [3:0] llamada_pendiente;
    logic [1:0] destino_asc_1, destino_asc_2;
    logic       destino_valido_asc_1, destino_valido_asc_2;
    logic       atendido_asc_1, atendido_asc_2;
    logic       timeout_asc_1, timeout_asc_2;

    int checks = 0;
    int errors = 0;
    int exp_q1[$];
    int exp_q2[$];
    int f1, f2;
    logic pv1 = 1'b0;
    logic pv2 = 1'b0;

    always #5 clk = ~clk;

    despachador_llamadas #(.TIMEOUT_CICLOS(20), .DEBOUNCE_CICLOS(8)) dut (
        .clk(clk),
        .rst(rst),
        .boton_llamada(boton_llamada),
        .piso_asc_1(piso_asc_1),
        .piso_asc_2(piso_asc_2),
        .puertas_abiertas_asc_1(puertas_abiertas_asc_1),
        .puertas_abiertas_asc_2(puertas_abiertas_asc_2),
        .llamada_pendiente(llamada_pendiente),
        .destino_asc_1(destino_asc_1),
        .destino_asc_2(destino_asc_2),
        .destino_valido_asc_1(destino_valido_asc_1),
        .destino_valido_asc_2(destino_valido_asc_2),
        .atendido_asc_1(atendido_asc_1),
        .atendido_asc_2(atendido_asc_2),
        .timeout_asc_1(timeout_asc_1),
        .timeout_asc_2(timeout_asc_2)
    );

    // Every rising valid flag must match the next expected destination of that elevator.
    always @(negedge clk) begin
        if (destino_valido_asc_1 === 1'b1 && pv1 === 1'b0) begin
            checks++;
            if (exp_q1.size() == 0) begin
                errors++;
                $display("FAIL assign_asc_1: got unexpected destino %0d, required no assignment", destino_asc_1);
            end else begin
                f1 = exp_q1.pop_front();
                if (destino_asc_1 !== 2'(f1)) begin
                    errors++;
                    $display("FAIL assign_asc_1: got destino %0d, required %0d", destino_asc_1, f1);
                end
            end
        end
        if (destino_valido_asc_2 === 1'b1 && pv2 === 1'b0) begin
            checks++;
            if (exp_q2.size() == 0) begin
                errors++;
                $display("FAIL assign_asc_2: got unexpected destino %0d, required no assignment", destino_asc_2);
            end else begin
                f2 = exp_q2.pop_front();
                if (destino_asc_2 !== 2'(f2)) begin
                    errors++;
                    $display("FAIL assign_asc_2: got destino %0d, required %0d", destino_asc_2, f2);
                end
            end
        end
        pv1 = destino_valido_asc_1;
        pv2 = destino_valido_asc_2;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int elev, input int budget, output int n);
        n = 0;
        for (int k = 1; k <= budget; k++) begin
            tick();
            if (((elev == 1) ? destino_valido_asc_1 : destino_valido_asc_2) === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic check_latency(input string name, input int n);
        checks++;
        if (n == 0) begin
            errors++;
            $display("FAIL %s: got no valid flag within budget, required assignment", name);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({llamada_pendiente, destino_asc_1, destino_asc_2, destino_valido_asc_1, destino_valido_asc_2,
             atendido_asc_1, atendido_asc_2, timeout_asc_1, timeout_asc_2} !== 16'h0) begin
            errors++;
            $display("FAIL %s: got lamps %b dest %0d/%0d valid %b%b pulses %b%b%b%b, required all 0", name,
                     llamada_pendiente, destino_asc_1, destino_asc_2, destino_valido_asc_1, destino_valido_asc_2,
                     atendido_asc_1, atendido_asc_2, timeout_asc_1, timeout_asc_2);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        boton_llamada = 4'b0000;
        piso_asc_1 = 2'd0;
        piso_asc_2 = 2'd0;
        puertas_abiertas_asc_1 = 1'b0;
        puertas_abiertas_asc_2 = 1'b0;
        tick();
        tick();
        check_outputs_zero("reset_state");
        rst = 1'b0;
        tick();
    endtask

    task automatic test_assign_tiebreak();
        int n;
        piso_asc_1 = 2'd1;
        piso_asc_2 = 2'd3;
        exp_q1.push_back(2);
        boton_llamada = 4'b0100;
        tick();
        checks++;
        if (llamada_pendiente !== 4'b0100) begin
            errors++;
            $display("FAIL lamp_latency: got %b, required 0100", llamada_pendiente);
        end
        boton_llamada = 4'b0000;
        wait_valid(1, 6, n);
        check_latency("tiebreak_latency", n);
        checks++;
        if (destino_valido_asc_2 !== 1'b0) begin
            errors++;
            $display("FAIL tiebreak_asc_2: got valid %b, required 0", destino_valido_asc_2);
        end
    endtask

    task automatic test_service();
        piso_asc_1 = 2'd2;
        puertas_abiertas_asc_1 = 1'b1;
        tick();
        checks++;
        if ({llamada_pendiente, destino_valido_asc_1, atendido_asc_1} !== 6'b0000_0_1) begin
            errors++;
            $display("FAIL service: got lamps %b valid %b atendido %b, required 0000 0 1",
                     llamada_pendiente, destino_valido_asc_1, atendido_asc_1);
        end
        puertas_abiertas_asc_1 = 1'b0;
        tick();
        checks++;
        if (atendido_asc_1 !== 1'b0) begin
            errors++;
            $display("FAIL atendido_width: got %b, required 0", atendido_asc_1);
        end
    endtask

    task automatic test_two_calls();
        int n;
        piso_asc_1 = 2'd0;
        piso_asc_2 = 2'd3;
        exp_q1.push_back(0);
        exp_q2.push_back(3);
        boton_llamada = 4'b1001;
        tick();
        checks++;
        if (llamada_pendiente !== 4'b1001) begin
            errors++;
            $display("FAIL two_calls_lamp: got %b, required 1001", llamada_pendiente);
        end
        boton_llamada = 4'b0000;
        n = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (destino_valido_asc_1 === 1'b1 && destino_valido_asc_2 === 1'b1) begin
                n = k;
                break;
            end
        end
        check_latency("two_calls_both_valid", n);
        checks++;
        if ({destino_asc_1, destino_asc_2} !== 4'b00_11) begin
            errors++;
            $display("FAIL two_calls_dest: got %0d/%0d, required 0/3", destino_asc_1, destino_asc_2);
        end
        puertas_abiertas_asc_1 = 1'b1;
        puertas_abiertas_asc_2 = 1'b1;
        tick();
        checks++;
        if ({llamada_pendiente, destino_valido_asc_1, destino_valido_asc_2, atendido_asc_1, atendido_asc_2} !== 8'b0000_00_11) begin
            errors++;
            $display("FAIL dual_service: got lamps %b valid %b%b atendido %b%b, required 0000 00 11",
                     llamada_pendiente, destino_valido_asc_1, destino_valido_asc_2, atendido_asc_1, atendido_asc_2);
        end
        puertas_abiertas_asc_1 = 1'b0;
        puertas_abiertas_asc_2 = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int n;
        piso_asc_1 = 2'd1;
        piso_asc_2 = 2'd1;
        exp_q1.push_back(0);
        boton_llamada = 4'b0001;
        tick();
        boton_llamada = 4'b0000;
        wait_valid(1, 6, n);
        check_latency("timeout_first_assign", n);
        n = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (timeout_asc_1 === 1'b1) begin
                n = k;
                break;
            end
        end
        checks++;
        if (n != 20) begin
            errors++;
            $display("FAIL timeout_count: got pulse after %0d cycles, required 20", n);
        end
        checks++;
        if ({destino_valido_asc_1, llamada_pendiente, atendido_asc_1} !== 6'b0_0001_0) begin
            errors++;
            $display("FAIL timeout_state: got valid %b lamps %b atendido %b, required 0 0001 0",
                     destino_valido_asc_1, llamada_pendiente, atendido_asc_1);
        end
        exp_q1.push_back(0);
        tick();
        checks++;
        if (timeout_asc_1 !== 1'b0) begin
            errors++;
            $display("FAIL timeout_width: got %b, required 0", timeout_asc_1);
        end
        wait_valid(1, 5, n);
        check_latency("timeout_reassign", n);
        piso_asc_1 = 2'd0;
        puertas_abiertas_asc_1 = 1'b1;
        tick();
        checks++;
        if ({atendido_asc_1, timeout_asc_1, llamada_pendiente} !== 6'b1_0_0000) begin
            errors++;
            $display("FAIL reassign_service: got atendido %b timeout %b lamps %b, required 1 0 0000",
                     atendido_asc_1, timeout_asc_1, llamada_pendiente);
        end
        puertas_abiertas_asc_1 = 1'b0;
        tick();
    endtask

    task automatic test_press_service_same();
        piso_asc_2 = 2'd1;
        boton_llamada = 4'b0010;
        puertas_abiertas_asc_2 = 1'b1;
        tick();
        checks++;
        if ({llamada_pendiente, atendido_asc_2} !== 5'b0000_0) begin
            errors++;
            $display("FAIL press_service_lamp: got lamps %b atendido %b, required 0000 0",
                     llamada_pendiente, atendido_asc_2);
        end
        for (int k = 0; k < 8; k++) tick();
        checks++;
        if ({llamada_pendiente, destino_valido_asc_1, destino_valido_asc_2} !== 6'b0000_00) begin
            errors++;
            $display("FAIL press_service_hold: got lamps %b valid %b%b, required 0000 00",
                     llamada_pendiente, destino_valido_asc_1, destino_valido_asc_2);
        end
        boton_llamada = 4'b0000;
        puertas_abiertas_asc_2 = 1'b0;
        tick();
    endtask

    task automatic test_cross_service();
        int n;
        piso_asc_1 = 2'd2;
        piso_asc_2 = 2'd0;
        exp_q1.push_back(2);
        boton_llamada = 4'b0100;
        tick();
        boton_llamada = 4'b0000;
        wait_valid(1, 6, n);
        check_latency("cross_assign", n);
        piso_asc_2 = 2'd2;
        puertas_abiertas_asc_2 = 1'b1;
        tick();
        checks++;
        if ({llamada_pendiente, destino_valido_asc_1, atendido_asc_1, atendido_asc_2} !== 7'b0000_0_0_0) begin
            errors++;
            $display("FAIL cross_service: got lamps %b valid1 %b atendido %b%b, required 0000 0 00",
                     llamada_pendiente, destino_valido_asc_1, atendido_asc_1, atendido_asc_2);
        end
        puertas_abiertas_asc_2 = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int n;
        piso_asc_1 = 2'd1;
        piso_asc_2 = 2'd1;
        exp_q1.push_back(3);
        boton_llamada = 4'b1000;
        tick();
        boton_llamada = 4'b0000;
        wait_valid(1, 6, n);
        check_latency("reset_mid_assign", n);
        rst = 1'b1;
        tick();
        check_outputs_zero("reset_mid_state");
        rst = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        check_outputs_zero("reset_mid_after");
    endtask

`ifdef DESPACHADOR_DEBOUNCE_EN
    task automatic test_debounce();
        int n;
        piso_asc_1 = 2'd0;
        piso_asc_2 = 2'd3;
        boton_llamada = 4'b0001;
        for (int k = 0; k < 5; k++) tick();
        boton_llamada = 4'b0000;
        for (int k = 0; k < 12; k++) tick();
        checks++;
        if (llamada_pendiente !== 4'b0000) begin
            errors++;
            $display("FAIL debounce_glitch: got %b, required 0000", llamada_pendiente);
        end
        exp_q1.push_back(0);
        boton_llamada = 4'b0001;
        for (int k = 0; k < 8; k++) tick();
        checks++;
        if (llamada_pendiente !== 4'b0000) begin
            errors++;
            $display("FAIL debounce_early: got %b, required 0000", llamada_pendiente);
        end
        tick();
        checks++;
        if (llamada_pendiente !== 4'b0001) begin
            errors++;
            $display("FAIL debounce_press: got %b, required 0001", llamada_pendiente);
        end
        wait_valid(1, 6, n);
        check_latency("debounce_assign", n);
        boton_llamada = 4'b0000;
    endtask
`endif

    initial begin
        test_reset();
`ifdef DESPACHADOR_DEBOUNCE_EN
        test_debounce();
`else
        test_assign_tiebreak();
        test_service();
        test_two_calls();
        test_timeout();
        test_press_service_same();
        test_cross_service();
        test_reset_mid();
`endif
        tick();
        checks++;
        if (exp_q1.size() != 0 || exp_q2.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d unmatched, required 0/0", exp_q1.size(), exp_q2.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
